sm83_fetch: RTL and testbench

Instruction-byte prefetch stage for the SM83 core. It drives the read address of the instruction memory (combinational read, data valid in the same cycle as address), captures returned bytes into a small FIFO tagged with their address, and presents them to the decoder over a valid/ready handshake. It supports a single-cycle redirect (jump/call/return/interrupt vector) that flushes the FIFO and restarts fetch at a new PC.

---
 rtl/sm83_fetch.sv | 160 ++++++++++++++++
 tb/tb_sm83_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_fetch.sv
// sm83_fetch -- instruction-byte prefetch stage for the SM83 core.
//
// Drives the instruction memory read address from the fetch PC. The returned
// byte (valid in the same cycle) is captured into a small FIFO together with
// its address. Entries are offered to the decoder over a valid/ready
// handshake. A redirect flushes the FIFO and restarts fetch at a new PC in a
// single cycle.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, an empty FIFO forwards the memory byte combinationally to
//   the decoder (zero fetch-to-valid latency). Bypassed bytes are never
//   counted in level.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, 2..16
//   RESET_PC  fetch PC loaded on reset
//
// Ports:
//   clk          core clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   en           fetch enable; low stops new fetches, FIFO still drains
//   mem_addr     instruction memory read address (fetch PC)
//   mem_data     byte at mem_addr, same cycle
//   redirect     flush FIFO and restart fetch at redirect_pc
//   redirect_pc  new fetch PC
//   op_valid     head entry available
//   op_data      head entry byte
//   op_pc        address of head entry byte
//   op_ready     decoder accepts head this cycle
//   level        current FIFO occupancy
module sm83_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic [15:0]                    mem_addr,
  input  logic [7:0]                     mem_data,
  input  logic                           redirect,
  input  logic [15:0]                    redirect_pc,
  output logic                           op_valid,
  output logic [7:0]                     op_data,
  output logic [15:0]                    op_pc,
  input  logic                           op_ready,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;

  logic [7:0]    entry_data_q [DEPTH];
  logic [15:0]   entry_pc_q   [DEPTH];

  logic fifo_valid;
  logic pop;
  logic push;
  logic bypass;
  logic bypass_take;

  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && op_ready;

`ifdef FETCH_BYPASS_EN
  // Empty FIFO: present the memory byte directly. If the decoder takes it,
  // the byte is consumed without ever entering the FIFO.
  assign bypass      = (count_q == '0) && en && !redirect;
  assign bypass_take = bypass && op_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A full FIFO that is popping this cycle still has room for the new byte.
  assign push = en && !redirect && !bypass_take &&
                ((count_q < CW'(DEPTH)) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // Remaining entries are dropped; a pop this cycle still hands its
      // byte to the decoder, which is why pop is not gated by redirect.
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push || bypass_take) begin
        fetch_pc_d = fetch_pc_q + 16'd1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: one register pair per entry so every entry can be cleared
  // by the asynchronous reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [7:0]  entry_data_d;
      logic [15:0] entry_pc_d;
      logic        entry_we;

      assign entry_we = push && (wr_ptr_q == PW'(gi));

      always_comb begin
        entry_data_d = entry_data_q[gi];
        entry_pc_d   = entry_pc_q[gi];
        if (entry_we) begin
          entry_data_d = mem_data;
          entry_pc_d   = fetch_pc_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_data_q[gi] <= 8'h00;
          entry_pc_q[gi]   <= 16'h0000;
        end else begin
          entry_data_q[gi] <= entry_data_d;
          entry_pc_q[gi]   <= entry_pc_d;
        end
      end
    end
  endgenerate

  assign mem_addr = fetch_pc_q;
  assign op_valid = fifo_valid || bypass;
  assign op_data  = bypass ? mem_data   : entry_data_q[rd_ptr_q];
  assign op_pc    = bypass ? fetch_pc_q : entry_pc_q[rd_ptr_q];
  assign level    = count_q;

endmodule

// File: tb/tb_sm83_fetch.sv
// Testbench for sm83_fetch (default build, DEPTH = 4, RESET_PC = 0).
// Stimulus pushes the expected {pc, byte} of every handshake into a queue;
// a monitor pops and compares on each accepted byte. Occupancy, address and
// head-entry values are checked directly at fixed points in the sequence.
module tb_sm83_fetch;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        op_valid;
  logic [7:0]  op_data;
  logic [15:0] op_pc;
  logic        op_ready;
  logic [2:0]  level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } exp_t;

  exp_t sb_q[$];

  sm83_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .op_valid    (op_valid),
    .op_data     (op_data),
    .op_pc       (op_pc),
    .op_ready    (op_ready),
    .level       (level)
  );

  // Instruction memory: first four bytes fixed, the rest a simple hash.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h3E;
      16'h0001: return 8'hBE;
      16'h0002: return 8'h3C;
      16'h0003: return 8'hFF;
      default:  return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  assign mem_data = mem_byte(mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
      $display("check %s: got %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic expect_op(input logic [15:0] pc, input logic [7:0] data);
    sb_q.push_back('{pc: pc, data: data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per accepted byte.
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      total_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_pop: got pc=%04h data=%02h, want none", op_pc, op_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (op_pc === e.pc && op_data === e.data) begin
          pass_cnt++;
          $display("pop pc=%04h data=%02h", op_pc, op_data);
        end else begin
          $display("FAIL pop: got pc=%04h data=%02h, want pc=%04h data=%02h",
                   op_pc, op_data, e.pc, e.data);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b1;
    en          = 1'b0;
    op_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_level",    32'(level),    32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_op_data",  32'(op_data),  32'h00);
    chk("rst_op_pc",    32'(op_pc),    32'h0000);

    @(posedge clk);
    tick();
    // Streaming with op_ready high: one byte per cycle, level stays 1.
    rst_n    = 1'b1;
    en       = 1'b1;
    op_ready = 1'b1;
    expect_op(16'h0000, 8'h3E);
    expect_op(16'h0001, 8'hBE);
    expect_op(16'h0002, 8'h3C);
    tick();
    chk("stream_level0", 32'(level),    32'd1);
    chk("stream_valid0", 32'(op_valid), 32'h1);
    chk("stream_pc0",    32'(op_pc),    32'h0000);
    tick();
    chk("stream_level1", 32'(level),    32'd1);
    chk("stream_addr1",  32'(mem_addr), 32'h0002);
    tick();
    chk("stream_level2", 32'(level),    32'd1);
    tick();
    op_ready = 1'b0;
    tick();
    chk("pre_reset_level", 32'(level), 32'd2);

    // Reset mid-stream takes effect immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(op_valid), 32'h0);
    chk("midrst_level", 32'(level),    32'h0);
    chk("midrst_addr",  32'(mem_addr), 32'h0000);
    tick();
    rst_n = 1'b1;

    // Fill with op_ready low: level 1,2,3,4 then holds, address frozen.
    tick();
    chk("fill_level1", 32'(level), 32'd1);
    tick();
    chk("fill_level2", 32'(level), 32'd2);
    tick();
    chk("fill_level3", 32'(level), 32'd3);
    tick();
    chk("fill_level4", 32'(level),    32'd4);
    chk("fill_addr4",  32'(mem_addr), 32'h0004);
    tick();
    chk("full_level",  32'(level),    32'd4);
    chk("full_addr",   32'(mem_addr), 32'h0004);
    chk("full_op_pc",  32'(op_pc),    32'h0000);
    chk("full_op_data",32'(op_data),  32'h3E);

    // Full FIFO, one cycle of op_ready: pop and push together.
    expect_op(16'h0000, 8'h3E);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("fullpop_level", 32'(level),    32'd4);
    chk("fullpop_addr",  32'(mem_addr), 32'h0005);
    chk("fullpop_op_pc", 32'(op_pc),    32'h0001);

    // Drain with en low: fetch PC held, remaining bytes in order.
    en       = 1'b0;
    op_ready = 1'b1;
    expect_op(16'h0001, 8'hBE);
    expect_op(16'h0002, 8'h3C);
    expect_op(16'h0003, 8'hFF);
    expect_op(16'h0004, 8'hA1);
    repeat (4) tick();
    chk("drain_level", 32'(level),    32'd0);
    chk("drain_valid", 32'(op_valid), 32'h0);
    chk("drain_addr",  32'(mem_addr), 32'h0005);

    // Redirect while level = 3.
    en       = 1'b1;
    op_ready = 1'b0;
    repeat (3) tick();
    chk("preredir_level", 32'(level), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 16'h0150;
    tick();
    redirect = 1'b0;
    chk("redir_level", 32'(level),    32'd0);
    chk("redir_valid", 32'(op_valid), 32'h0);
    chk("redir_addr",  32'(mem_addr), 32'h0150);
    tick();
    chk("redir_valid2", 32'(op_valid), 32'h1);
    chk("redir_op_pc",  32'(op_pc),    32'h0150);
    chk("redir_op_data",32'(op_data),  32'hF4);

    // Redirect with a pop in the same cycle, then PC wrap at 16'hFFFF.
    expect_op(16'h0150, 8'hF4);
    op_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_addr",  32'(mem_addr), 32'hFFFE);
    chk("wrap_valid", 32'(op_valid), 32'h0);
    expect_op(16'hFFFE, 8'hA4);
    expect_op(16'hFFFF, 8'hA5);
    expect_op(16'h0000, 8'h3E);
    expect_op(16'h0001, 8'hBE);
    tick();
    chk("wrap_op_pc0", 32'(op_pc), 32'hFFFE);
    repeat (4) tick();
    op_ready = 1'b0;
    en       = 1'b0;
    chk("wrap_level",   32'(level),    32'd1);
    chk("wrap_op_pc",   32'(op_pc),    32'h0002);
    chk("wrap_op_data", 32'(op_data),  32'h3C);
    chk("wrap_addr_end",32'(mem_addr), 32'h0003);
    tick();
    chk("idle_level", 32'(level), 32'd1);
    chk("sb_empty",   32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
